noc_vc_input_port: RTL

NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

---
 rtl/noc_vc_input_port_if.sv | 37 +++
 rtl/noc_vc_input_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_input_port_if.sv
// Flit input, flit output and credit return signals of the VC input port.
// The port module uses the slave modport; the upstream/downstream driver
// (router core or bench) uses the master modport.
interface noc_vc_input_port_if #(
   parameter int FLIT_W = 64,
   parameter int NUM_VC = 4
);
   localparam int VCW = $clog2(NUM_VC);

   logic              in_valid;
   logic [VCW-1:0]    in_vc;
   logic              in_head;
   logic              in_tail;
   logic [FLIT_W-1:0] in_flit;

   logic              out_valid;
   logic [VCW-1:0]    out_vc;
   logic              out_head;
   logic              out_tail;
   logic [FLIT_W-1:0] out_flit;
   logic              out_ready;

   logic              credit_valid;
   logic [VCW-1:0]    credit_vc;

   modport slave (
      input  in_valid, in_vc, in_head, in_tail, in_flit, out_ready,
      output out_valid, out_vc, out_head, out_tail, out_flit,
      output credit_valid, credit_vc
   );

   modport master (
      output in_valid, in_vc, in_head, in_tail, in_flit, out_ready,
      input  out_valid, out_vc, out_head, out_tail, out_flit,
      input  credit_valid, credit_vc
   );
endinterface

// File: rtl/noc_vc_input_port.sv
// NoC virtual-channel input port: one FIFO per VC, packet-atomic output
// selection (IDLE / LOCKED FSM), per-flit credit return, congestion and
// overflow flags, forwarded-packet counter.
// Optional feature macro NOC_VC_QOS_PRIO_EN: strict priority (highest
// eligible VC wins) instead of round-robin arbitration in IDLE.
module noc_vc_input_port #(
   parameter  int FLIT_W      = 64,
   parameter  int NUM_VC      = 4,
   parameter  int VC_DEPTH    = 4,
   parameter  int CONG_THRESH = 3,
   localparam int VCW         = $clog2(NUM_VC),
   localparam int OCW         = $clog2(VC_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   noc_vc_input_port_if.slave    bus,
   output logic [NUM_VC*OCW-1:0] occupancy,
   output logic                  congestion,
   output logic                  overflow_err,
   output logic [31:0]           pkts_fwd
);
   localparam int PW = $clog2(VC_DEPTH);
   localparam int EW = FLIT_W + 2;   // {head, tail, flit}

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [VCW-1:0]    lock_vc_reg, lock_vc_next;
   logic [VCW-1:0]    rr_ptr_reg, rr_ptr_next;
   logic              hold_vld_reg;
   logic [VCW-1:0]    hold_vc_reg;
   logic              credit_valid_reg;
   logic [VCW-1:0]    credit_vc_reg;
   logic              cong_reg, ovf_reg;
   logic [31:0]       pkts_reg;

   logic [OCW-1:0]    count_w  [NUM_VC];
   logic [EW-1:0]     front_w  [NUM_VC];
   logic [NUM_VC-1:0] eligible;
   logic [NUM_VC-1:0] wr_en;
   logic [NUM_VC-1:0] deq;

   logic              grant_found;
   logic [VCW-1:0]    grant_vc;
   logic [VCW-1:0]    sel_vc;
   logic              out_valid_c;
   logic              xfer;
   logic              ovf_hit;
   logic              cong_any;

   // ---------------- per-VC FIFOs ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         logic [EW-1:0]  mem [VC_DEPTH];
         logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
         logic [OCW-1:0] count_reg;

         // Fullness is judged on the start-of-cycle count, so a write to a
         // full VC is dropped even if that VC dequeues on the same edge.
         assign wr_en[gi] = bus.in_valid && (bus.in_vc == VCW'(gi)) &&
                            (count_reg != OCW'(VC_DEPTH));
         assign deq[gi]   = xfer && (sel_vc == VCW'(gi));

         // Payload storage; contents are meaningless while the VC is empty.
         always_ff @(posedge clk) begin
            if (wr_en[gi]) mem[wr_ptr_reg] <= {bus.in_head, bus.in_tail, bus.in_flit};
         end

         // Pointers wrap naturally (VC_DEPTH is a power of two); count tracks fill.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (wr_en[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
               if (deq[gi])   rd_ptr_reg <= rd_ptr_reg + PW'(1);
               case ({wr_en[gi], deq[gi]})
                  2'b10:   count_reg <= count_reg + OCW'(1);
                  2'b01:   count_reg <= count_reg - OCW'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end

         assign count_w[gi]                 = count_reg;
         assign front_w[gi]                 = mem[rd_ptr_reg];
         assign eligible[gi]                = (count_reg != '0) && front_w[gi][EW-1];
         assign occupancy[gi*OCW +: OCW]    = count_reg;
      end
   endgenerate

   // ---------------- IDLE arbiter ----------------
   // Picks a VC whose front flit is a head; a grant stalled by out_ready=0
   // is held so the presented flit cannot change under backpressure.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_vc    = '0;
`ifdef NOC_VC_QOS_PRIO_EN
      for (int i = 0; i < NUM_VC; i++) begin
         if (eligible[i]) begin
            grant_found = 1'b1;
            grant_vc    = VCW'(i);
         end
      end
`else
      // Scan offsets from the pointer downward so the nearest one wins.
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= NUM_VC) idx = idx - NUM_VC;
         if (eligible[idx]) begin
            grant_found = 1'b1;
            grant_vc    = VCW'(idx);
         end
      end
`endif
      if (hold_vld_reg) begin
         grant_found = 1'b1;
         grant_vc    = hold_vc_reg;
      end
   end

   // ---------------- output selector FSM ----------------
   // State register plus arbitration bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         lock_vc_reg  <= '0;
         rr_ptr_reg   <= '0;
         hold_vld_reg <= 1'b0;
         hold_vc_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         lock_vc_reg  <= lock_vc_next;
         rr_ptr_reg   <= rr_ptr_next;
         hold_vld_reg <= (state_reg == ST_IDLE) && out_valid_c && !bus.out_ready;
         hold_vc_reg  <= sel_vc;
      end
   end

   // Next state: lock onto a multi-flit packet, release on its tail.
   always_comb begin
      state_next   = state_reg;
      lock_vc_next = lock_vc_reg;
      rr_ptr_next  = rr_ptr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (xfer) begin
               rr_ptr_next = (sel_vc == VCW'(NUM_VC - 1)) ? '0 : sel_vc + VCW'(1);
               if (!front_w[sel_vc][EW-2]) begin
                  state_next   = ST_LOCKED;
                  lock_vc_next = sel_vc;
               end
            end
         end
         default: begin
            if (xfer && front_w[sel_vc][EW-2]) state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs: present the granted (IDLE) or owning (LOCKED) VC's front flit.
   always_comb begin
      sel_vc      = (state_reg == ST_IDLE) ? grant_vc : lock_vc_reg;
      out_valid_c = (state_reg == ST_IDLE) ? grant_found : (count_w[lock_vc_reg] != '0);
      xfer        = out_valid_c && bus.out_ready;
   end

   assign bus.out_valid    = out_valid_c;
   assign bus.out_vc       = sel_vc;
   assign bus.out_head     = front_w[sel_vc][EW-1];
   assign bus.out_tail     = front_w[sel_vc][EW-2];
   assign bus.out_flit     = front_w[sel_vc][FLIT_W-1:0];
   assign bus.credit_valid = credit_valid_reg;
   assign bus.credit_vc    = credit_vc_reg;

   // ---------------- status ----------------
   // Congestion and overflow detection from start-of-cycle counts.
   always_comb begin
      ovf_hit  = bus.in_valid && (count_w[bus.in_vc] == OCW'(VC_DEPTH));
      cong_any = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (count_w[i] >= OCW'(CONG_THRESH)) cong_any = 1'b1;
      end
   end

   // Credit pulse one cycle after each transfer; flags and packet counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_valid_reg <= 1'b0;
         credit_vc_reg    <= '0;
         cong_reg         <= 1'b0;
         ovf_reg          <= 1'b0;
         pkts_reg         <= '0;
      end else begin
         credit_valid_reg <= xfer;
         credit_vc_reg    <= xfer ? sel_vc : credit_vc_reg;
         cong_reg         <= cong_any;
         ovf_reg          <= ovf_reg | ovf_hit;
         if (xfer && bus.out_tail) pkts_reg <= pkts_reg + 32'd1;
      end
   end

   assign congestion   = cong_reg;
   assign overflow_err = ovf_reg;
   assign pkts_fwd     = pkts_reg;
endmodule
